// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch front end. It issues one instruction-memory
//            request at a time and buffers the returned instructions in a
//            small FIFO for decode. A jump flushes the FIFO and drops any
//            response that is still in flight.
// Ports    : clk, reset           - clock, asynchronous active-high reset
//            pc_in, jump, pc_stall - program counter interface
//            imem_*               - instruction memory request/response
//            if_*, id_ready       - queue head presented to decode
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic        jump,
    output logic        pc_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready
);

    localparam int c_AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(QUEUE_DEPTH);
    localparam logic [c_CW-1:0] c_ONE   = c_CW'(1);

    generate
        if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_depth_check
            $error("fetch_unit: QUEUE_DEPTH must be a power of two and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t          r_state;
    logic [31:0]     r_pending_pc;
    logic [31:0]     r_q_instr [QUEUE_DEPTH];
    logic [31:0]     r_q_pc    [QUEUE_DEPTH];
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_CW-1:0] r_count;

    logic            w_grant;
    logic            w_pop;
    logic            w_push;
    logic [c_CW-1:0] w_count_after_pop;
    logic [c_CW-1:0] w_count_post_push;

    assign w_grant = (r_state == S_REQ) && imem_gnt;
    // A flush wins over both decode acceptance and returning data.
    assign w_pop   = if_valid && id_ready && !jump;
    assign w_push  = (r_state == S_WAIT) && imem_rvalid && !jump;

    assign w_count_after_pop = r_count - {{c_AW{1'b0}}, w_pop};
    assign w_count_post_push = w_count_after_pop + c_ONE;

    assign imem_req  = (r_state == S_REQ);
    assign imem_addr = pc_in;
    // The PC may only advance in the cycle its address is accepted.
    assign pc_stall  = !w_grant;

    assign if_valid  = (r_count != '0);
    assign if_instr  = if_valid ? r_q_instr[r_rd_ptr] : 32'd0;
    assign if_pc     = if_valid ? r_q_pc[r_rd_ptr]    : 32'd0;

    // Control state, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pending_pc <= 32'd0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
        end else begin
            if (jump) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                r_count <= w_count_after_pop + {{c_AW{1'b0}}, w_push};
            end

            case (r_state)
                S_IDLE: begin
                    // A flush empties the queue, so there is always room.
                    if (jump || (w_count_after_pop < c_DEPTH)) r_state <= S_REQ;
                end
                S_REQ: begin
                    if (imem_gnt) begin
                        r_pending_pc <= pc_in;
                        // Granted on the old PC while redirecting: its data is stale.
                        r_state      <= jump ? S_DROP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (jump || (w_count_post_push < c_DEPTH)) r_state <= S_REQ;
                        else                                        r_state <= S_IDLE;
                    end else if (jump) begin
                        r_state <= S_DROP;
                    end
                end
                S_DROP: begin
                    // The stale response closes the transaction; a further
                    // jump only keeps us here while it is still outstanding.
                    if (imem_rvalid) r_state <= S_REQ;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Queue storage; contents are only meaningful below r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_wr_ptr] <= imem_rdata;
            r_q_pc[r_wr_ptr]    <= r_pending_pc;
        end
    end

    // Protocol checks.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(w_push && !w_pop && (r_count == c_DEPTH)))
                else $error("fetch_unit: push into a full queue");
            assert (!(imem_rvalid && ((r_state == S_IDLE) || (r_state == S_REQ))))
                else $warning("fetch_unit: response with no outstanding request");
        end
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter QUEUE_DEPTH, default 2: instruction queue entries; power of two, >=2.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 pc_in  input  32  current fetch address from the program counter.
REQ-005 jump  input  1  redirect/flush; same signal that loads the program counter.
REQ-006 pc_stall  output  1  high = program counter must hold; low = PC may advance this cycle.
REQ-007 imem_req  output  1  instruction memory request.
REQ-008 imem_addr  output  32  request address.
REQ-009 imem_gnt  input  1  memory accepted the request this cycle.
REQ-010 imem_rvalid  input  1  read data valid.
REQ-011 imem_rdata  input  32  read data.
REQ-012 if_valid  output  1  queue head holds a valid instruction.
REQ-013 if_instr  output  32  instruction at queue head.
REQ-014 if_pc  output  32  address of the queue-head instruction.
REQ-015 id_ready  input  1  decode accepts the head entry this cycle.

Function
REQ-016 States SHALL be IDLE, REQ, WAIT, DROP; at most one memory request outstanding.
REQ-017 imem_req SHALL be 1 only in REQ; imem_addr SHALL equal pc_in combinationally.
REQ-018 REQ: on imem_gnt, latch pc_in as pending_pc, go to WAIT; with no grant, stay in REQ.
REQ-019 pc_stall SHALL be 0 only in a cycle where state==REQ and imem_gnt==1; otherwise 1.
REQ-020 WAIT: on imem_rvalid, push {pending_pc, imem_rdata}, then go to REQ if post-push count < QUEUE_DEPTH, else go to IDLE.
REQ-021 IDLE: go to REQ when count < QUEUE_DEPTH, evaluated after any pop in the same cycle.
REQ-022 Entry from IDLE to REQ SHALL occur only when count < QUEUE_DEPTH, so a push never overflows; a push when count==QUEUE_DEPTH is an assertion failure.
REQ-023 Pop SHALL occur when if_valid && id_ready && !jump; simultaneous push and pop SHALL leave count unchanged.
REQ-024 if_valid = (count != 0); if_instr and if_pc SHALL reflect the head entry and be 0 when empty.
REQ-025 Flush (jump==1): queue SHALL be emptied at the clock edge; a pop requested in that cycle is ignored.
REQ-026 Flush in WAIT without rvalid, or in REQ with imem_gnt: go to DROP; the next rvalid is discarded, then go to REQ.
REQ-027 Flush in WAIT with rvalid in the same cycle: discard that data, go to REQ.
REQ-028 Flush in REQ without grant, or in IDLE: go to or stay in REQ; the next request uses the redirected pc_in.
REQ-029 Flush in DROP: remain in DROP.
REQ-030 imem_rvalid in IDLE or REQ SHALL be ignored and flagged by assertion.
REQ-031 Queue pointers SHALL wrap modulo QUEUE_DEPTH; count width SHALL be log2(QUEUE_DEPTH)+1.

Reset
REQ-032 While reset is high: state=IDLE, queue empty, pending_pc=0, drop condition cleared.
REQ-033 While reset is high: if_valid=0, if_instr=0, if_pc=0, imem_req=0, pc_stall=1.
REQ-034 Reset assertion mid-request SHALL abandon the outstanding transaction.
REQ-035 The first cycle after reset release SHALL be IDLE, moving to REQ on the next edge.

Verification
REQ-036 Streaming: pc_in 0,4,8; gnt every REQ cycle; rvalid 1 cycle after gnt; id_ready=1 -> if_pc sequence 0,4,8 with matching rdata; pc_stall low once per fetch.
REQ-037 Backpressure: id_ready=0, depth 2 -> after 2 pushes state IDLE, imem_req=0, pc_stall=1; id_ready=1 for one cycle -> exactly one new request.
REQ-038 Flush in WAIT: gnt at pc=0x10, jump with pc_in=0x80 before rvalid -> response for 0x10 discarded; next if_pc=0x80.
REQ-039 Flush and rvalid in the same cycle, queue holding 1 entry -> queue empty, rvalid data dropped, imem_req=1 on the next cycle.
REQ-040 Memory stall: gnt withheld 5 cycles -> imem_req held high, pc_stall=1 throughout, imem_addr stable.
REQ-041 Reset asserted in WAIT with 1 queued entry -> if_valid=0 immediately; a later stray rvalid is ignored.
